// File: rtl/dmem_stall_ctrl.sv
// Data-memory stage controller: turns EX/MEM load/store fields into a req/ack
// transaction on a variable-latency memory port and stalls the pipeline meanwhile.
module dmem_stall_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        halt,
  input  logic [15:0] addr,
  input  logic [15:0] writeData,
  output logic        memStall,
  output logic [15:0] readDataOut,
  output logic        doneOut,
  output logic        errOut,
  output logic        memReq,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memWData,
  input  logic        memAck,
  input  logic [15:0] memRData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       req;
  logic       timeout;

  // A combined read+write is treated as a write.
  assign req     = (memRead | memWrite) & ~halt;
  assign timeout = (wait_cnt == 8'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every output is given a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    memReq     = 1'b0;
    memStall   = 1'b0;
    doneOut    = 1'b0;
    unique case (state)
      IDLE: begin
        memStall = req;
        if (req) state_next = BUSY;
      end
      BUSY: begin
        memReq   = 1'b1;
        memStall = 1'b1;
        if (memAck || timeout) state_next = DONE;
      end
      DONE: begin
        doneOut    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE and held; memReq alone qualifies them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memWr       <= 1'b0;
      memAddr     <= 16'h0000;
      memWData    <= 16'h0000;
      readDataOut <= 16'h0000;
      errOut      <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            memAddr  <= addr;
            memWData <= writeData;
            memWr    <= memWrite;
            wait_cnt <= 8'd0;
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (memAck) begin
            if (!memWr) readDataOut <= memRData;
          end else if (timeout) begin
            // Ack in the timeout cycle takes priority, so errOut is only set here.
            errOut <= 1'b1;
            if (!memWr) readDataOut <= 16'hFFFF;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed bench for dmem_stall_ctrl: a scoreboard holds the expected load result
// and error flag per transaction and is checked on each doneOut strobe.
module tb_dmem_stall_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, halt;
  logic [15:0] addr, writeData;
  logic        memStall, doneOut, errOut, memReq, memWr;
  logic [15:0] readDataOut, memAddr, memWData;
  logic        memAck;
  logic [15:0] memRData;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_rd  = 16'h0000;
  logic        model_err = 1'b0;

  dmem_stall_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .halt       (halt),
    .addr       (addr),
    .writeData  (writeData),
    .memStall   (memStall),
    .readDataOut(readDataOut),
    .doneOut    (doneOut),
    .errOut     (errOut),
    .memReq     (memReq),
    .memWr      (memWr),
    .memAddr    (memAddr),
    .memWData   (memWData),
    .memAck     (memAck),
    .memRData   (memRData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle and sample 2 time units after the edge; pop the scoreboard on doneOut.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #2;
    if (doneOut === 1'b1) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("done_rdata", readDataOut, e.data);
        check("done_err", errOut, e.err);
      end
    end
  endtask

  // One memory op from IDLE; k = ack position within BUSY (1 = first cycle), 0 = never ack.
  task automatic mem_op(input string tag, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] wd,
                        input int k, input logic [15:0] rdata);
    int   high;
    int   stall;
    exp_t e;
    memRead = rd; memWrite = wr; halt = 1'b0; addr = a; writeData = wd;
    #1;
    check({tag, ":stall_idle"}, memStall, 1);
    check({tag, ":req_idle"}, memReq, 0);
    if (wr)          e.data = model_rd;
    else if (k == 0) e.data = 16'hFFFF;
    else             e.data = rdata;
    if (k == 0) model_err = 1'b1;
    e.err    = model_err;
    model_rd = e.data;
    sb.push_back(e);
    stall = 1;
    high  = 0;
    cyc();
    memRead = 1'b0; memWrite = 1'b0; addr = 16'h0000; writeData = 16'h0000;
    check({tag, ":addr"}, memAddr, a);
    check({tag, ":wr"}, memWr, wr);
    check({tag, ":wdata"}, memWData, wd);
    while (memReq === 1'b1 && high < 64) begin
      high++;
      if (memStall === 1'b1) stall++;
      if (high == k) begin
        memAck   = 1'b1;
        memRData = rdata;
      end
      cyc();
      memAck   = 1'b0;
      memRData = 16'h0000;
    end
    check({tag, ":req_cycles"}, high, (k == 0) ? TIMEOUT : k);
    check({tag, ":stall_cycles"}, stall, high + 1);
    check({tag, ":done"}, doneOut, 1);
    check({tag, ":stall_done"}, memStall, 0);
    cyc();
    check({tag, ":done_one_cycle"}, doneOut, 0);
  endtask

  initial begin
    rst = 1'b0;
    memRead = 1'b1; memWrite = 1'b0; halt = 1'b0;
    addr = 16'h0010; writeData = 16'h0000;
    memAck = 1'b0; memRData = 16'h0000;

    // Held in reset with a pending load: nothing may issue.
    cyc();
    cyc();
    check("rst:memReq", memReq, 0);
    check("rst:doneOut", doneOut, 0);
    check("rst:errOut", errOut, 0);
    check("rst:memWr", memWr, 0);
    check("rst:memAddr", memAddr, 0);
    check("rst:memWData", memWData, 0);
    check("rst:readDataOut", readDataOut, 0);
    rst = 1'b1;

    mem_op("first_load", 1'b1, 1'b0, 16'h0010, 16'h0000, 2, 16'h1111);
    mem_op("load_beef", 1'b1, 1'b0, 16'h0040, 16'hAAAA, 3, 16'hBEEF);
    mem_op("store_both", 1'b1, 1'b1, 16'h0080, 16'h1234, 1, 16'hDEAD);

    // Stray ack in IDLE changes nothing.
    memAck = 1'b1; memRData = 16'h5555;
    cyc();
    memAck = 1'b0; memRData = 16'h0000;
    check("stray_idle:memReq", memReq, 0);
    check("stray_idle:doneOut", doneOut, 0);
    check("stray_idle:rdata", readDataOut, model_rd);

    mem_op("ack_at_timeout", 1'b1, 1'b0, 16'h00A0, 16'h0000, TIMEOUT, 16'h7A7A);
    check("ack_at_timeout:err", errOut, 0);

    // Halted store: no request, no stall.
    memWrite = 1'b1; halt = 1'b1; addr = 16'h00C0;
    #1;
    check("halt:stall", memStall, 0);
    cyc();
    check("halt:memReq", memReq, 0);
    check("halt:doneOut", doneOut, 0);
    memWrite = 1'b0; halt = 1'b0;

    mem_op("timeout_load", 1'b1, 1'b0, 16'h0100, 16'h0000, 0, 16'h0000);
    mem_op("b2b_load1", 1'b1, 1'b0, 16'h0200, 16'h0000, 2, 16'h2222);
    mem_op("b2b_load2", 1'b1, 1'b0, 16'h0202, 16'h0000, 1, 16'h3333);
    check("err_sticky", errOut, 1);

    // Reset during BUSY: memReq drops at once and the request is not reissued.
    memRead = 1'b1; addr = 16'h0300;
    cyc();
    memRead = 1'b0;
    check("midrst:busy", memReq, 1);
    rst = 1'b0;
    #1;
    check("midrst:req_async", memReq, 0);
    check("midrst:err_clear", errOut, 0);
    model_rd  = 16'h0000;
    model_err = 1'b0;
    #1;
    rst = 1'b1;
    memAck = 1'b1; memRData = 16'h6666;
    cyc();
    memAck = 1'b0; memRData = 16'h0000;
    check("midrst:no_done", doneOut, 0);
    check("midrst:no_reissue", memReq, 0);
    cyc();
    check("midrst:still_idle", memReq | doneOut, 0);
    check("midrst:rdata", readDataOut, 0);

    mem_op("post_rst_load", 1'b1, 1'b0, 16'h0400, 16'h0000, 2, 16'h4444);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
